// File: rtl/booth_csa_reducer_if.sv
// booth_csa_reducer_if: operand/result handshake bundle for the Booth carry-save reducer
interface booth_csa_reducer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum_vec;
    logic [31:0] carry_vec;
    logic        busy;
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum_vec, carry_vec, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum_vec, carry_vec, busy
    );
endinterface

// File: rtl/booth_csa_reducer.sv
// booth_csa_reducer: radix-4 Booth multiplier that folds one partial product per cycle into carry-save S/C
module booth_csa_reducer (
    input logic                 clk,
    input logic                 rst,
    booth_csa_reducer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nx;
    logic [15:0] a_q, b_q;
    logic [31:0] s_q, c_q;
    logic [2:0]  cnt;
    logic [16:0] bx;
    logic [2:0]  dig;
    logic        zero, two, neg;
    logic [31:0] a_ext, mag, shifted, pp, s_nx, maj;
    assign bx    = {b_q, 1'b0};
    assign dig   = bx[{cnt, 1'b0} +: 3];
    assign a_ext = {{16{a_q[15]}}, a_q};
    always_comb begin
        zero    = (dig == 3'b000) || (dig == 3'b111);
        two     = (dig == 3'b011) || (dig == 3'b100);
        neg     = dig[2] && !zero;
        mag     = zero ? 32'd0 : (two ? {a_ext[30:0], 1'b0} : a_ext);
        shifted = mag << {cnt, 1'b0};
        pp      = neg ? ~shifted : shifted;
        s_nx    = s_q ^ c_q ^ pp;
        maj     = (s_q & c_q) | (s_q & pp) | (c_q & pp);
    end
    // the +1 of a negated partial product lands in the always-empty LSB of the shifted carry
    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.in_valid) state_nx = RUN;
        if (state == RUN && cnt == 3'd7) state_nx = DONE;
        if (state == DONE && bus.out_ready) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.in_valid) begin
                a_q <= bus.a;
                b_q <= bus.b;
                s_q <= '0;
                c_q <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                s_q <= s_nx;
                c_q <= {maj[30:0], neg};
                cnt <= cnt + 3'd1;
            end
        end
    end
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum_vec   = (state == DONE) ? s_q : 32'd0;
    assign bus.carry_vec = (state == DONE) ? c_q : 32'd0;
endmodule

// File: tb/tb_booth_csa_reducer.sv
// tb_booth_csa_reducer: directed and small randomized checks of the Booth carry-save reducer
module tb_booth_csa_reducer;
    logic clk = 0;
    logic rst = 1;
    int   errors = 0;
    int   checks = 0;
    booth_csa_reducer_if bus();
    booth_csa_reducer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one transaction; flags any RUN cycle with wrong outputs and any instability during hold
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                         output logic [31:0] res, output int lat, output bit run_bad,
                         output bit hold_bad, output bit to);
        logic [31:0] s0, c0;
        int w = 0;
        to = 0; run_bad = 0; hold_bad = 0; lat = 0;
        bus.a = a; bus.b = b; bus.in_valid = 1; bus.out_ready = 0;
        while (!bus.in_ready && w < 40) begin step(); w++; end
        if (!bus.in_ready) to = 1;
        step();
        bus.in_valid = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready || !bus.busy || bus.sum_vec !== 0 || bus.carry_vec !== 0) run_bad = 1;
            step();
            lat++;
        end
        if (!bus.out_valid) to = 1;
        res = bus.sum_vec + bus.carry_vec;
        s0 = bus.sum_vec; c0 = bus.carry_vec;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!bus.out_valid || bus.in_ready || bus.sum_vec !== s0 || bus.carry_vec !== c0) hold_bad = 1;
        end
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.in_valid = 1; bus.a = 16'd9; bus.b = 16'd9; bus.out_ready = 0;
        step(); step();
        rst = 0; bus.in_valid = 0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sum_vec !== 32'd0) begin errors++; $display("FAIL reset_sum got=%h exp=0", bus.sum_vec); end
        checks++; if (bus.carry_vec !== 32'd0) begin errors++; $display("FAIL reset_carry got=%h exp=0", bus.carry_vec); end
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat; bit rb, hb, to;
        do_op(16'd3, 16'd2, 0, r, lat, rb, hb, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8 edges after accept", lat); end
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL basic_product got=%h exp=00000006", r); end
        checks++; if (rb) begin errors++; $display("FAIL basic_run_outputs got=bad exp=in_ready0 busy1 vectors0"); end
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_release got=%b%b exp=10", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_corners();
        logic [15:0] av [3] = '{16'h8000, 16'hFFFF, 16'h0000};
        logic [15:0] bv [3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
        logic [31:0] ev [3] = '{32'h40000000, 32'hFFFF8001, 32'h00000000};
        logic [31:0] r; int lat; bit rb, hb, to;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], 0, r, lat, rb, hb, to);
            checks++; if (to || r !== ev[i]) begin errors++; $display("FAIL corner_%0d got=%h exp=%h", i, r, ev[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int lat; bit rb, hb, to;
        do_op(16'd100, 16'hFFF9, 5, r, lat, rb, hb, to);
        checks++; if (to || r !== 32'hFFFFFD44) begin errors++; $display("FAIL bp_product got=%h exp=fffffd44", r); end
        checks++; if (hb) begin errors++; $display("FAIL bp_stable got=changed exp=stable"); end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=10", bus.in_ready, bus.busy); end
    endtask

    task automatic test_ignore();
        int w = 0;
        logic [31:0] r;
        bus.a = 16'd10; bus.b = 16'd20; bus.in_valid = 1; bus.out_ready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.a = 16'(i * 37 + 1); bus.b = 16'(16'hF000 + i);
            step();
        end
        bus.in_valid = 0;
        while (!bus.out_valid && w < 40) begin step(); w++; end
        r = bus.sum_vec + bus.carry_vec;
        checks++; if (!bus.out_valid || r !== 32'd200) begin errors++; $display("FAIL ignore_product got=%h exp=000000c8", r); end
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat; bit rb, hb, to; bit saw = 0;
        bus.a = 16'd1234; bus.b = 16'd77; bus.in_valid = 1;
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) step();
        rst = 1;
        step();
        rst = 0;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum_vec !== 0 || bus.carry_vec !== 0)
            begin errors++; $display("FAIL midrst_state got=%b%b%b %h %h exp=100 0 0", bus.in_ready, bus.busy, bus.out_valid, bus.sum_vec, bus.carry_vec); end
        for (int i = 0; i < 12; i++) begin step(); if (bus.out_valid) saw = 1; end
        checks++; if (saw) begin errors++; $display("FAIL midrst_no_valid got=pulse exp=none"); end
        do_op(16'd5, 16'd5, 0, r, lat, rb, hb, to);
        checks++; if (to || r !== 32'h19) begin errors++; $display("FAIL midrst_after got=%h exp=00000019", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; bit rb, hb, to;
        logic [15:0] a, b;
        int p, bad = 0, first_bad = -1;
        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            p = int'($signed(a)) * int'($signed(b));
            do_op(a, b, int'($urandom_range(0, 2)), r, lat, rb, hb, to);
            checks++;
            if (to || r !== p[31:0] || lat != 8 || hb) begin
                errors++;
                $display("FAIL b2b_%0d a=%h b=%h got=%h exp=%h lat=%0d", n, a, b, r, p[31:0], lat);
            end
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.out_ready = 0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/booth_csa_reducer.md
BOOTH_CSA_REDUCER -- requirements
Module: booth_csa_reducer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  16  signed multiplicand, two's complement.
REQ-007 b  input  16  signed multiplier, two's complement.
REQ-008 out_valid  output  1  sum_vec/carry_vec hold a finished result.
REQ-009 out_ready  input  1  downstream final-adder stage accepts the result.
REQ-010 sum_vec  output  32  carry-save sum vector.
REQ-011 carry_vec  output  32  carry-save carry vector, already weighted (shifted) and ready for direct addition.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1, out_valid=0.
REQ-015 An input handshake SHALL occur when in_valid&in_ready is high on a clock edge; on that edge the block SHALL capture a and b, clear S and C to 0, set the digit counter to 0, and enter RUN.
REQ-016 RUN: in_ready=0 and out_valid=0; in_valid SHALL be ignored; changes on a/b after capture SHALL have no effect.
REQ-017 RUN SHALL process one radix-4 Booth digit per cycle, i = 0..7, with digit i taken from captured bits (b[2i+1], b[2i], b[2i-1]) and b[-1]=0.
REQ-018 Booth digit decode SHALL be: 000->0, 001->+1, 010->+1, 011->+2, 100->-2, 101->-1, 110->-1, 111->0.
REQ-019 The partial product SHALL be PP_i = (d_i * sign_extend32(a)) << 2i, modulo 2^32.
REQ-020 Each RUN cycle SHALL apply a 3:2 compression to (S, C, PP_i): S' = S^C^PP_i and C' = majority(S, C, PP_i) << 1, all truncated to 32 bits.
REQ-021 Negation of a partial product SHALL be done by bitwise inversion plus a +1 correction folded into the compression; no full-width carry-propagate adder is permitted in the datapath.
REQ-022 After each RUN cycle, (S + C) mod 2^32 SHALL equal the sum of PP_0..PP_i, modulo 2^32.
REQ-023 When digit 7 has been processed, the counter SHALL wrap 7->0 and the FSM SHALL enter DONE.
REQ-024 Latency: with the handshake on edge T, out_valid SHALL first be high in the cycle following edge T+8 (9 cycles after acceptance).
REQ-025 DONE: out_valid=1, in_ready=0, sum_vec=S, carry_vec=C.
REQ-026 In DONE, sum_vec and carry_vec SHALL hold stable while out_ready=0, with no timeout.
REQ-027 In DONE with out_ready=1 on an edge, the FSM SHALL return to IDLE; in_ready becomes 1 the next cycle, with no same-cycle bypass of accept and release.
REQ-028 In DONE, (sum_vec + carry_vec) mod 2^32 SHALL equal the exact signed 32-bit product a*b; this SHALL hold for all 2^32 operand pairs, including a = b = -32768.
REQ-029 sum_vec and carry_vec SHALL read 0 in IDLE and RUN; only DONE exposes S and C.
REQ-030 out_ready SHALL be ignored outside DONE.

Reset
REQ-031 On rst=1 at an edge: FSM->IDLE, S=0, C=0, counter=0, captured operands=0.
REQ-032 Outputs after reset SHALL be: in_ready=1, out_valid=0, busy=0, sum_vec=0, carry_vec=0.
REQ-033 Reset SHALL take priority over any simultaneous handshake; if asserted mid-RUN or mid-DONE, the in-flight result SHALL be discarded and no out_valid pulse emitted.

Verification
REQ-034 a=3, b=2, out_ready=1 -> out_valid high exactly 9 cycles after acceptance; sum_vec+carry_vec = 0x00000006.
REQ-035 a=-32768, b=-32768 -> sum_vec+carry_vec = 0x40000000; a=-1, b=32767 -> 0xFFFF8001; a=0, b=-1 -> 0x00000000.
REQ-036 Backpressure: a=100, b=-7, out_ready held 0 for 5 cycles after out_valid -> vectors stable, sum = 0xFFFFFD44 (-700), then release -> IDLE next cycle, in_ready=1.
REQ-037 in_valid held high during RUN with changing a/b -> ignored; result matches the captured operands.
REQ-038 rst pulsed at RUN digit 4 -> next cycle IDLE, all outputs 0, no out_valid; a subsequent a=5, b=5 -> 0x00000019.
REQ-039 Random regression, 10^5 signed pairs with random out_ready -> (sum+carry) mod 2^32 equals the reference product, and one result per accepted pair.
